// File: rtl/instr_decode_stage.sv
// -----------------------------------------------------------------------------
// instr_decode_stage
//
// RISC-V style decode stage with a two-entry elastic buffer: a main output
// register plus a skid register. Incoming words are decoded combinationally
// and registered, so out_valid follows an accepted input by one cycle.
//
// Ports
//   clk, rst_n            single clock, asynchronous active-low reset
//   flush                 synchronous discard of both buffered entries
//   in_valid / in_ready   upstream handshake (in_ready = !skid_valid)
//   instruction, pc       raw 32-bit word and its XLEN-bit address
//   out_valid / out_ready downstream handshake
//   out_pc                PC of the presented entry
//   opcode..func7         raw instruction fields of the presented entry
//   imm                   sign-extended immediate (0 for R and ILLEGAL)
//   fmt                   R=0 I=1 S=2 B=3 U=4 J=5 ILLEGAL=7
//   illegal               presented entry is undecodable
//   illegal_cnt           saturating count of accepted ILLEGAL entries
// -----------------------------------------------------------------------------
module instr_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       opcode,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [2:0]       func3,
    output logic [6:0]       func7,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam bit IS_RV64 = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    entry_t           dec;
    entry_t           out_q;
    entry_t           skid_q;
    logic             out_valid_q;
    logic             skid_valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             op_unknown;
    logic [31:0]      imm32;
    logic             accept;
    logic             stalled;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    always_comb begin
        // An X/Z anywhere in the opcode byte makes the word undecodable; in
        // synthesis this term folds to 0.
        op_unknown = ((^instruction[6:0]) === 1'bx);

        dec        = '0;
        dec.pc     = pc;
        dec.opcode = op_unknown ? 5'd0 : instruction[6:2];
        dec.rd     = instruction[11:7];
        dec.rs1    = instruction[19:15];
        dec.rs2    = instruction[24:20];
        dec.func3  = instruction[14:12];
        dec.func7  = instruction[31:25];
        dec.fmt    = FMT_ILL;

        if (!op_unknown && (instruction[1:0] == 2'b11)) begin
            case (instruction[6:2])
                5'b01100: dec.fmt = FMT_R;
                5'b01110: dec.fmt = IS_RV64 ? FMT_R : FMT_ILL;
                5'b00000,
                5'b00011,
                5'b00100,
                5'b11001,
                5'b11100: dec.fmt = FMT_I;
                5'b00110: dec.fmt = IS_RV64 ? FMT_I : FMT_ILL;
                5'b01000: dec.fmt = FMT_S;
                5'b11000: dec.fmt = FMT_B;
                5'b01101,
                5'b00101: dec.fmt = FMT_U;
                5'b11011: dec.fmt = FMT_J;
                default:  dec.fmt = FMT_ILL;
            endcase
        end

        dec.illegal = (dec.fmt == FMT_ILL);

        imm32 = '0;
        case (dec.fmt)
            FMT_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
            FMT_S: imm32 = {{20{instruction[31]}}, instruction[31:25],
                            instruction[11:7]};
            FMT_B: imm32 = {{19{instruction[31]}}, instruction[31],
                            instruction[7], instruction[30:25],
                            instruction[11:8], 1'b0};
            FMT_U: imm32 = {instruction[31:12], 12'b0};
            FMT_J: imm32 = {{11{instruction[31]}}, instruction[31],
                            instruction[19:12], instruction[20],
                            instruction[30:21], 1'b0};
            default: imm32 = '0;
        endcase

        // Fill with the sign first, then overlay the low word; works for
        // both XLEN=32 and XLEN=64 without a zero-width replication.
        dec.imm       = {XLEN{imm32[31]}};
        dec.imm[31:0] = imm32;
    end

    // ------------------------------------------------------------------
    // Two-entry elastic buffer
    // ------------------------------------------------------------------
    assign accept  = in_valid & in_ready;
    assign stalled = out_valid_q & ~out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!stalled) begin
            // Output is empty or handing off this cycle. The skid entry is
            // older than anything on the input (in_ready is low while it is
            // held), so it always goes first.
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end

    // Counts only entries actually kept: a flushed same-cycle accept is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && !flush && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = ~skid_valid_q;
    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign opcode      = out_q.opcode;
    assign rd          = out_q.rd;
    assign rs1         = out_q.rs1;
    assign rs2         = out_q.rs2;
    assign func3       = out_q.func3;
    assign func7       = out_q.func7;
    assign imm         = out_q.imm;
    assign fmt         = out_q.fmt;
    assign illegal     = out_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_decode_stage
//
// Bench for instr_decode_stage. One XLEN=32 instance carries the main
// scenarios through a scoreboard queue; an XLEN=64 instance with a 2-bit
// counter covers RV64-only opcodes, 64-bit sign extension and counter
// saturation.
// -----------------------------------------------------------------------------
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  opcode, rd, rs1, rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
    logic [15:0] illegal_cnt;

    logic        f64, v64, r64, ov64, or64, ill64;
    logic [31:0] ins64;
    logic [63:0] pc64, opc_pc64, imm64;
    logic [4:0]  opc64, rd64, rs1_64, rs2_64;
    logic [2:0]  f3_64, fmt64;
    logic [6:0]  f7_64;
    logic [1:0]  cnt64;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        illegal;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    instr_decode_stage #(.XLEN(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .func3(func3), .func7(func7), .imm(imm), .fmt(fmt),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    instr_decode_stage #(.XLEN(64), .CNT_W(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(f64),
        .in_valid(v64), .in_ready(r64),
        .instruction(ins64), .pc(pc64),
        .out_valid(ov64), .out_ready(or64), .out_pc(opc_pc64),
        .opcode(opc64), .rd(rd64), .rs1(rs1_64), .rs2(rs2_64),
        .func3(f3_64), .func7(f7_64), .imm(imm64), .fmt(fmt64),
        .illegal(ill64), .illegal_cnt(cnt64)
    );

    // Expected entry: register fields are plain slices of the word; opcode,
    // fmt and imm are given explicitly by each scenario.
    function automatic exp_t mk(input logic [31:0] p, input logic [31:0] w,
                                input logic [2:0] f, input logic [31:0] im,
                                input logic [4:0] opc);
        exp_t e;
        e.pc      = p;
        e.opcode  = opc;
        e.rd      = w[11:7];
        e.rs1     = w[19:15];
        e.rs2     = w[24:20];
        e.func3   = w[14:12];
        e.func7   = w[31:25];
        e.imm     = im;
        e.fmt     = f;
        e.illegal = (f == 3'd7);
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t a;
        a.pc      = out_pc;
        a.opcode  = opcode;
        a.rd      = rd;
        a.rs1     = rs1;
        a.rs2     = rs2;
        a.func3   = func3;
        a.func7   = func7;
        a.imm     = imm;
        a.fmt     = fmt;
        a.illegal = illegal;
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t zero = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (illegal_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_illegal_cnt: got %0d want 0", illegal_cnt); end
        n_cmp++; if (observed() !== zero) begin n_bad++; $display("FAIL reset_data: got %h want %h", observed(), zero); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        exp_t e;
        out_ready   = 1'b1;
        instruction = 32'hFFF1_0093;
        pc          = 32'h0000_0100;
        in_valid    = 1'b1;
        sb.push_back(mk(32'h100, 32'hFFF1_0093, 3'd1, 32'hFFFF_FFFF, 5'b00100));
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        e = sb.pop_front();
        n_cmp++; if (observed() !== e) begin n_bad++; $display("FAIL addi_entry: got %h want %h", observed(), e); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL addi_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_branch_lui();
        exp_t e;
        out_ready   = 1'b1;
        instruction = 32'hFE20_8EE3;
        pc          = 32'h0000_0200;
        in_valid    = 1'b1;
        sb.push_back(mk(32'h200, 32'hFE20_8EE3, 3'd3, 32'hFFFF_FFFC, 5'b11000));
        tick();
        e = sb.pop_front();
        n_cmp++; if (observed() !== e || out_valid !== 1'b1) begin n_bad++; $display("FAIL beq_entry: got %h v=%b want %h", observed(), out_valid, e); end
        instruction = 32'h1234_52B7;
        pc          = 32'h0000_0204;
        sb.push_back(mk(32'h204, 32'h1234_52B7, 3'd4, 32'h1234_5000, 5'b01101));
        tick();
        in_valid = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (observed() !== e || out_valid !== 1'b1) begin n_bad++; $display("FAIL lui_entry: got %h v=%b want %h", observed(), out_valid, e); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lui_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'h0050_0113;
        pc          = 32'h0000_0300;
        sb.push_back(mk(32'h300, 32'h0050_0113, 3'd1, 32'h0000_0005, 5'b00100));
        tick();
        instruction = 32'h0020_81B3;
        pc          = 32'h0000_0304;
        sb.push_back(mk(32'h304, 32'h0020_81B3, 3'd0, 32'h0000_0000, 5'b01100));
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_in_ready_low: got %b want 0", in_ready); end
        n_cmp++; if (observed() !== sb[0]) begin n_bad++; $display("FAIL b2b_a_presented: got %h want %h", observed(), sb[0]); end
        // A third word must be refused while both entries are full.
        instruction = 32'h0000_0013;
        pc          = 32'h0000_0308;
        repeat (2) tick();
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_stall_flags: got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid); end
        n_cmp++; if (observed() !== sb[0]) begin n_bad++; $display("FAIL b2b_a_held: got %h want %h", observed(), sb[0]); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e = sb.pop_front();
        n_cmp++; if (observed() !== e) begin n_bad++; $display("FAIL b2b_first_out: got %h want %h", observed(), e); end
        tick();
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_refill_flags: got rdy=%b v=%b want rdy=1 v=1", in_ready, out_valid); end
        e = sb.pop_front();
        n_cmp++; if (observed() !== e) begin n_bad++; $display("FAIL b2b_second_out: got %h want %h", observed(), e); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_extra_output: got %b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        exp_t        e;
        logic [31:0] xw;
        xw        = 32'h1234_5000;
        xw[6:0]   = 7'bxxxxxxx;
        out_ready = 1'b1;
        instruction = 32'h0000_0000;
        pc          = 32'h0000_0400;
        in_valid    = 1'b1;
        sb.push_back(mk(32'h400, 32'h0000_0000, 3'd7, 32'h0, 5'd0));
        tick();
        e = sb.pop_front();
        n_cmp++; if (observed() !== e || out_valid !== 1'b1) begin n_bad++; $display("FAIL illegal_zero_word: got %h v=%b want %h", observed(), out_valid, e); end
        instruction = xw;
        pc          = 32'h0000_0404;
        sb.push_back(mk(32'h404, 32'h1234_5000, 3'd7, 32'h0, 5'd0));
        tick();
        in_valid = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (observed() !== e || out_valid !== 1'b1) begin n_bad++; $display("FAIL illegal_x_word: got %h v=%b want %h", observed(), out_valid, e); end
        n_cmp++; if (illegal_cnt !== 16'd2) begin n_bad++; $display("FAIL illegal_count: got %0d want 2", illegal_cnt); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL illegal_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'h0050_0113;
        pc          = 32'h0000_0500;
        tick();
        instruction = 32'h0020_81B3;
        pc          = 32'h0000_0504;
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_full_before: got rdy=%b want 0", in_ready); end
        flush       = 1'b1;
        instruction = 32'h0000_0000;
        pc          = 32'h0000_0508;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_full_after: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_emit: got %b want 0 (cycle %0d)", out_valid, i); end
        end
        // Flush beats a same-cycle accept into an empty stage.
        flush       = 1'b1;
        in_valid    = 1'b1;
        instruction = 32'h0000_0000;
        pc          = 32'h0000_0510;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_beats_accept: got %b want 0", out_valid); end
        n_cmp++; if (illegal_cnt !== 16'd2) begin n_bad++; $display("FAIL flush_keeps_count: got %0d want 2", illegal_cnt); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_accept_late: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midstall();
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'h0050_0113;
        pc          = 32'h0000_0600;
        tick();
        pc          = 32'h0000_0604;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL midstall_async: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        n_cmp++; if (illegal_cnt !== 16'd0) begin n_bad++; $display("FAIL midstall_count: got %0d want 0", illegal_cnt); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midstall_release: got %b want 0", out_valid); end
    endtask

    task automatic test_xlen64();
        exp_t e;
        // OP-32 word: R on RV64, illegal on RV32.
        or64        = 1'b1;
        ins64       = 32'h0000_003B;
        pc64        = 64'h0000_0001_0000_0000;
        v64         = 1'b1;
        out_ready   = 1'b1;
        instruction = 32'h0000_003B;
        pc          = 32'h0000_0700;
        in_valid    = 1'b1;
        sb.push_back(mk(32'h700, 32'h0000_003B, 3'd7, 32'h0, 5'b01110));
        tick();
        in_valid = 1'b0;
        n_cmp++; if (ov64 !== 1'b1 || fmt64 !== 3'd0 || ill64 !== 1'b0) begin n_bad++; $display("FAIL rv64_op32: got v=%b fmt=%0d ill=%b want v=1 fmt=0 ill=0", ov64, fmt64, ill64); end
        n_cmp++; if (opc_pc64 !== 64'h0000_0001_0000_0000) begin n_bad++; $display("FAIL rv64_pc: got %h want 0000000100000000", opc_pc64); end
        e = sb.pop_front();
        n_cmp++; if (observed() !== e) begin n_bad++; $display("FAIL rv32_op32: got %h want %h", observed(), e); end
        ins64 = 32'hFFF1_0093;
        tick();
        n_cmp++; if (fmt64 !== 3'd1 || imm64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL rv64_addi: got fmt=%0d imm=%h want fmt=1 imm=ffffffffffffffff", fmt64, imm64); end
        ins64 = 32'h8234_52B7;
        tick();
        n_cmp++; if (fmt64 !== 3'd4 || imm64 !== 64'hFFFF_FFFF_8234_5000) begin n_bad++; $display("FAIL rv64_lui_sext: got fmt=%0d imm=%h want fmt=4 imm=ffffffff82345000", fmt64, imm64); end
        ins64 = 32'h0000_001B;
        tick();
        n_cmp++; if (fmt64 !== 3'd1) begin n_bad++; $display("FAIL rv64_opimm32: got fmt=%0d want 1", fmt64); end
        // Five illegal words into a 2-bit counter: must stop at 3.
        ins64 = 32'h0000_0000;
        repeat (5) tick();
        v64 = 1'b0;
        n_cmp++; if (cnt64 !== 2'd3) begin n_bad++; $display("FAIL rv64_cnt_saturate: got %0d want 3", cnt64); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instruction = '0; pc = '0;
        f64 = 1'b0; v64 = 1'b0; or64 = 1'b1; ins64 = '0; pc64 = '0;

        test_reset();
        test_addi();
        test_branch_lui();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_reset_midstall();
        test_xlen64();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the illegal-instruction counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream instruction valid.
REQ-007 SHALL have port in_ready, output, 1 bit: stage can accept an instruction.
REQ-008 SHALL have port instruction, input, 32 bits: raw instruction word.
REQ-009 SHALL have port pc, input, XLEN bits: instruction address.
REQ-010 SHALL have port out_valid, output, 1 bit: decoded entry valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-012 SHALL have port out_pc, output, XLEN bits: PC of the decoded entry.
REQ-013 SHALL have ports opcode (5), rd (5), rs1 (5), rs2 (5), func3 (3) and func7 (7), all outputs: instruction[6:2], [11:7], [19:15], [24:20], [14:12] and [31:25].
REQ-014 SHALL have port imm, output, XLEN bits: the sign-extended immediate.
REQ-015 SHALL have port fmt, output, 3 bits: R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7.
REQ-016 SHALL have port illegal, output, 1 bit: the entry is undecodable.
REQ-017 SHALL have port illegal_cnt, output, CNT_W bits: number of illegal instructions accepted.

Function
REQ-018 SHALL decode fmt from opcode:
- R: 01100, and 01110 when XLEN=64.
- I: 00000, 00011, 00100, 11001, 11100, and 00110 when XLEN=64.
- S: 01000.
- B: 11000.
- U: 01101, 00101.
- J: 11011.
- Any other opcode is ILLEGAL.
REQ-019 SHALL mark an entry ILLEGAL when instruction[1:0] != 2'b11 or any bit of instruction[6:0] is X/Z; in the X/Z case opcode SHALL be output as 0.
REQ-020 SHALL form imm as follows, sign bit always instruction[31], extended to XLEN:
- I: [31:20]
- S: {[31:25],[11:7]}
- B: {[31],[7],[30:25],[11:8],0}
- U: {[31:12],12'b0}
- J: {[31],[19:12],[20],[30:21],0}
- R and ILLEGAL: imm=0.
REQ-021 SHALL register all decoded outputs, giving 1-cycle latency from an accepted input to out_valid.
REQ-022 SHALL accept an input only when in_valid&in_ready, and hand off an output only when out_valid&out_ready.
REQ-023 SHALL buffer two entries, a main output register plus a skid register; in_ready SHALL be registered and equal to !skid_valid.
REQ-024 SHALL handle acceptance as follows:
- Accept while the output is empty or handing off: the entry loads the output register.
- Accept while the output is stalled (out_valid & !out_ready): the entry loads the skid register, and in_ready drops the next cycle.
REQ-025 SHALL move the skid entry to the output register on a handoff while skid_valid, reasserting in_ready the next cycle; order SHALL be preserved.
REQ-026 SHALL hold all outputs stable while out_valid & !out_ready.
REQ-027 SHALL clear out_valid and skid_valid on flush, with in_ready=1 the next cycle; flush SHALL take priority over a same-cycle accept, and that accept SHALL be discarded.
REQ-028 SHALL increment illegal_cnt by 1 per accepted ILLEGAL entry, saturating at all-ones; flush SHALL NOT clear it.

Reset
REQ-029 SHALL, while rst_n=0, force out_valid=0, skid_valid=0, in_ready=1, illegal_cnt=0, and all data outputs to 0.
REQ-030 SHALL, when reset asserts mid-stall, discard both entries immediately; out_valid SHALL be 0 on the first edge after release.

Verification
REQ-031 SHALL check: accept 0xFFF10093 (addi x1,x2,-1) at pc=0x100 -> next cycle out_valid=1, fmt=1, rd=1, rs1=2, imm=0xFFFFFFFF, out_pc=0x100.
REQ-032 SHALL check: 0xFE208EE3 (beq x1,x2,-4) -> fmt=3, rs1=1, rs2=2, imm=0xFFFFFFFC; 0x123452B7 (lui x5) -> fmt=4, rd=5, imm=0x12345000.
REQ-033 SHALL check: out_ready=0 with back-to-back A then B accepted -> in_ready=0 after B, A held stable; out_ready=1 -> A then B emitted in order, in_ready=1.
REQ-034 SHALL check: 0x00000000, then a word with X in bits [6:0] -> both illegal=1, fmt=7, imm=0, illegal_cnt=2, and opcode=0 for the X word.
REQ-035 SHALL check: flush asserted with both entries full plus a same-cycle in_valid -> out_valid=0, in_ready=1, nothing later emitted.
REQ-036 SHALL check: XLEN=64 with 0x0000003B (OP-32) -> fmt=0; the same word at XLEN=32 -> fmt=7.
